// File: rtl/h75_pixel_writer.sv
// RGB888 stream to RGB565 framebuffer writer with line/frame geometry checking.
// Optional saturating error counter enabled by defining H75_PIXWR_ERRCNT_EN.
module h75_pixel_writer #(
    parameter int unsigned ROWS   = 64,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        pixels_per_row,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [23:0]       s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              err
`ifdef H75_PIXWR_ERRCNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    localparam int unsigned COL_W = 10;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned SUM_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [COL_W-1:0]  ppr, ppr_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [SUM_W-1:0]  line_base, line_base_nxt;
    logic              wr_en_nxt, err_nxt, frame_done_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [15:0]       wr_data_nxt;

    logic              accept;
    logic [15:0]       pix565;
    logic [COL_W-1:0]  last_col;
    logic [SUM_W-1:0]  sum;
    logic              last_row;
    logic              pix_unused;

    assign accept     = s_valid && s_ready;
    assign pix565     = {s_data[23:19], s_data[15:10], s_data[7:3]};
    assign last_col   = ppr - COL_W'(1);
    assign sum        = line_base + SUM_W'(col);
    assign last_row   = (row == ROW_W'(ROWS - 1));
    assign pix_unused = &{1'b0, s_data[18:16], s_data[9:8], s_data[2:0]};

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ppr        <= '0;
            col        <= '0;
            row        <= '0;
            line_base  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            s_ready    <= 1'b0;
        end else begin
            state      <= state_nxt;
            ppr        <= ppr_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            line_base  <= line_base_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            err        <= err_nxt;
            frame_done <= frame_done_nxt;
            s_ready    <= 1'b1;
        end
    end

    // Next-state: SOF restarts from any state; overflow has priority over line checks
    always_comb begin
        state_nxt      = state;
        ppr_nxt        = ppr;
        col_nxt        = col;
        row_nxt        = row;
        line_base_nxt  = line_base;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = wr_addr;
        wr_data_nxt    = wr_data;
        err_nxt        = 1'b0;
        frame_done_nxt = 1'b0;

        if (accept) begin
            if (s_sof) begin
                ppr_nxt = pixels_per_row;
                err_nxt = (state == ACTIVE);
                if (pixels_per_row == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt     = ACTIVE;
                    col_nxt       = COL_W'(1);
                    row_nxt       = '0;
                    line_base_nxt = '0;
                    wr_en_nxt     = 1'b1;
                    wr_addr_nxt   = '0;
                    wr_data_nxt   = pix565;
                end
            end else if (state == ACTIVE) begin
                if (sum[ADDR_W]) begin
                    err_nxt   = 1'b1;
                    state_nxt = DRAIN;
                end else if (s_eol && (col == last_col)) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = sum[ADDR_W-1:0];
                    wr_data_nxt = pix565;
                    if (last_row) begin
                        frame_done_nxt = 1'b1;
                        state_nxt      = IDLE;
                    end else begin
                        col_nxt       = '0;
                        row_nxt       = row + ROW_W'(1);
                        line_base_nxt = line_base + SUM_W'(ppr);
                    end
                end else if (s_eol || (col >= last_col)) begin
                    err_nxt   = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = sum[ADDR_W-1:0];
                    wr_data_nxt = pix565;
                    col_nxt     = col + COL_W'(1);
                end
            end
        end
    end

`ifdef H75_PIXWR_ERRCNT_EN
    // Saturating count of err pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_h75_pixel_writer.sv
// Directed self-checking bench for h75_pixel_writer (ROWS=64 and ROWS=128 instances).
// Checks err_count too when H75_PIXWR_ERRCNT_EN is defined.
module tb_h75_pixel_writer;

    localparam int unsigned ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        ppr;
    logic              s_valid, s_sof, s_eol;
    logic [23:0]       s_data;

    logic              a_ready, a_wr_en, a_done, a_err;
    logic [ADDR_W-1:0] a_addr;
    logic [15:0]       a_data, a_cnt;
    logic              b_ready, b_wr_en, b_done, b_err;
    logic [ADDR_W-1:0] b_addr;
    logic [15:0]       b_data, b_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    h75_pixel_writer #(.ROWS(64), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .reset(reset), .pixels_per_row(ppr),
        .s_valid(s_valid), .s_ready(a_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
        .wr_en(a_wr_en), .wr_addr(a_addr), .wr_data(a_data),
        .frame_done(a_done), .err(a_err)
`ifdef H75_PIXWR_ERRCNT_EN
        , .err_count(a_cnt)
`endif
    );

    h75_pixel_writer #(.ROWS(128), .ADDR_W(ADDR_W)) u_ovf (
        .clk(clk), .reset(reset), .pixels_per_row(ppr),
        .s_valid(s_valid), .s_ready(b_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
        .wr_en(b_wr_en), .wr_addr(b_addr), .wr_data(b_data),
        .frame_done(b_done), .err(b_err)
`ifdef H75_PIXWR_ERRCNT_EN
        , .err_count(b_cnt)
`endif
    );

`ifndef H75_PIXWR_ERRCNT_EN
    assign a_cnt = '0;
    assign b_cnt = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic sof, input logic eol, input logic [23:0] d);
        @(negedge clk);
        s_valid = 1'b1; s_sof = sof; s_eol = eol; s_data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; ppr = '0; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_wr_en", a_wr_en, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_data", a_data, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
`ifdef H75_PIXWR_ERRCNT_EN
        chk("rst_cnt", a_cnt, 0);
`endif
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_up", a_ready, 1);

        // Full frame 128 x 64
        ppr = 10'd128;
        for (int k = 0; k < 8192; k++) begin
            beat(k == 0, (k % 128) == 127, 24'hFF8040);
            chk("ff_wr_en", a_wr_en, 1);
            chk("ff_addr", a_addr, k);
            chk("ff_data", a_data, 16'hFC08);
            chk("ff_done", a_done, (k == 8191) ? 1 : 0);
            chk("ff_err", a_err, 0);
        end
        idle_cycle();
        chk("ff_idle_wr_en", a_wr_en, 0);
        chk("ff_idle_done", a_done, 0);

        // Short line: eol at column 10 of row 2
        ppr = 10'd64;
        for (int k = 0; k < 138; k++) begin
            beat(k == 0, (k % 64) == 63, 24'h00FF00);
            chk("sl_wr_en", a_wr_en, 1);
            chk("sl_addr", a_addr, k);
            chk("sl_data", a_data, 16'h07E0);
            chk("sl_err", a_err, 0);
        end
        beat(1'b0, 1'b1, 24'h00FF00);
        chk("sl_bad_wr_en", a_wr_en, 0);
        chk("sl_bad_err", a_err, 1);
        for (int k = 0; k < 4; k++) begin
            beat(1'b0, k == 3, 24'h00FF00);
            chk("sl_drain_wr_en", a_wr_en, 0);
            chk("sl_drain_err", a_err, 0);
        end
        beat(1'b1, 1'b0, 24'hF80000);
        chk("sl_sof_wr_en", a_wr_en, 1);
        chk("sl_sof_addr", a_addr, 0);
        chk("sl_sof_data", a_data, 16'hF800);
        chk("sl_sof_err", a_err, 0);

        // Long line: continue row 0, omit eol at column 63
        for (int c = 1; c < 63; c++) begin
            beat(1'b0, 1'b0, 24'h0000F8);
            chk("ll_wr_en", a_wr_en, 1);
            chk("ll_addr", a_addr, c);
            chk("ll_data", a_data, 16'h001F);
        end
        beat(1'b0, 1'b0, 24'h0000F8);
        chk("ll_bad_wr_en", a_wr_en, 0);
        chk("ll_bad_err", a_err, 1);
        for (int k = 0; k < 4; k++) begin
            beat(1'b0, k == 1, 24'h0000F8);
            chk("ll_drain_wr_en", a_wr_en, 0);
            chk("ll_drain_err", a_err, 0);
        end

        // SOF mid-frame at row 5 column 3, ppr 32, with an idle gap
        ppr = 10'd32;
        beat(1'b1, 1'b0, 24'h808080);
        chk("sm_first_wr_en", a_wr_en, 1);
        chk("sm_first_addr", a_addr, 0);
        chk("sm_first_data", a_data, 16'h8410);
        chk("sm_first_err", a_err, 0);
        for (int k = 1; k < 163; k++) begin
            if (k == 100) begin
                idle_cycle();
                chk("sm_gap_wr_en", a_wr_en, 0);
            end
            beat(1'b0, (k % 32) == 31, 24'h808080);
            chk("sm_wr_en", a_wr_en, 1);
            chk("sm_addr", a_addr, k);
        end
        beat(1'b1, 1'b0, 24'h000000);
        chk("sm_sof_wr_en", a_wr_en, 1);
        chk("sm_sof_addr", a_addr, 0);
        chk("sm_sof_data", a_data, 16'h0000);
        chk("sm_sof_err", a_err, 1);
        beat(1'b0, 1'b0, 24'hFFFFFF);
        chk("sm_next_addr", a_addr, 1);
        chk("sm_next_data", a_data, 16'hFFFF);
        chk("sm_next_err", a_err, 0);

        // Address overflow on the ROWS=128 instance, ppr 512
        @(negedge clk); reset = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        ppr = 10'd512;
        for (int k = 0; k < 32768; k++) begin
            beat(k == 0, (k % 512) == 511, 24'h123456);
            chk("ov_wr_en", b_wr_en, 1);
            chk("ov_addr", b_addr, k);
            chk("ov_err", b_err, 0);
        end
        chk("ov_last_data", b_data, 16'h11AA);
        beat(1'b0, 1'b0, 24'h123456);
        chk("ov_bad_wr_en", b_wr_en, 0);
        chk("ov_bad_err", b_err, 1);
`ifdef H75_PIXWR_ERRCNT_EN
        chk("ov_cnt", b_cnt, 1);
`endif
        beat(1'b0, 1'b0, 24'h123456);
        chk("ov_drain_wr_en", b_wr_en, 0);
        chk("ov_drain_err", b_err, 0);

        // Reset the cycle after an accepted beat
        beat(1'b1, 1'b0, 24'hFF8040);
        chk("ar_pre_wr_en", a_wr_en, 1);
        reset = 1'b1;
        #1;
        chk("ar_wr_en", a_wr_en, 0);
        chk("ar_addr", a_addr, 0);
        chk("ar_data", a_data, 0);
        chk("ar_err", a_err, 0);
        chk("ar_done", a_done, 0);
        chk("ar_ready", a_ready, 0);
        chk("ar_b_wr_en", b_wr_en, 0);
`ifdef H75_PIXWR_ERRCNT_EN
        chk("ar_b_cnt", b_cnt, 0);
`endif
        @(negedge clk); reset = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        chk("ar_ready_up", a_ready, 1);
        beat(1'b0, 1'b0, 24'hFF8040);
        chk("ar_nosof_wr_en", a_wr_en, 0);
        chk("ar_nosof_b_wr_en", b_wr_en, 0);
        chk("ar_nosof_err", a_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
